// File: rtl/rtlola_event_feeder.sv
// rtl/rtlola_event_feeder.sv - event FIFO and paced newX1/newX2 pulse driver for the RTLola monitor
//
// Purpose:
//   Queues host events (x1/x2 values plus per-stream presence flags) and
//   presents them to the monitor one at a time as single-cycle newX1/newX2
//   pulses. Consecutive pulses are spaced MIN_GAP enabled cycles apart so
//   the monitor's internal transfers can settle between events.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              global enable shared with the monitor; freezes pacing/pops
//   s_valid/s_ready host event handshake (push when both high)
//   s_x1, s_x2      event values
//   s_has_x1/x2     event carries a new value for that stream
//   x1, x2          held monitor inputs (last issued values)
//   newX1, newX2    one-cycle event pulses
//   busy            FIFO non-empty or pacing gap in progress
//   fifo_level      number of queued events
//   event_cnt       issued pulse count, wraps at 16 bits

module rtlola_event_feeder #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3,
  parameter int MIN_GAP    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_x1,
  input  logic [DATA_W-1:0] s_x2,
  input  logic              s_has_x1,
  input  logic              s_has_x2,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic              newX1,
  output logic              newX2,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_level,
  output logic [15:0]       event_cnt
);

  localparam int ENTRY_W = 2 * DATA_W + 2;
  localparam int GAP_W   = $clog2(MIN_GAP);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(FIFO_DEPTH);

  // After a flagged pop the FSM sits in GAP for MIN_GAP-1 enabled cycles,
  // so the next pop lands MIN_GAP enabled cycles after the previous one and
  // the registered pulses inherit the same spacing.
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 2);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GAP  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  logic [ENTRY_W-1:0] head;
  logic [DATA_W-1:0]  head_x1;
  logic [DATA_W-1:0]  head_x2;
  logic               head_has_x1;
  logic               head_has_x2;
  logic               head_flagged;

  assign full  = (count == FULL_LEVEL);
  assign empty = (count == '0);

  // Ready is purely !full (not gated by a same-cycle pop), and is held low
  // while reset is asserted so nothing is accepted into a FIFO being flushed.
  assign s_ready = !rst && !full;
  assign push    = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_has_x2, s_has_x1, s_x2, s_x1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head         = mem[rd_ptr];
  assign head_x1      = head[DATA_W-1:0];
  assign head_x2      = head[2*DATA_W-1:DATA_W];
  assign head_has_x1  = head[2*DATA_W];
  assign head_has_x2  = head[2*DATA_W+1];
  assign head_flagged = head_has_x1 || head_has_x2;

  // ---------------------------------------------------------------------
  // Pacing FSM
  // ---------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_nxt;
  logic             issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    case (state)
      S_IDLE: begin
        // Flagless heads are dropped without entering GAP, so the next
        // entry may be popped on the very next cycle.
        if (en && !empty && head_flagged) begin
          state_nxt = S_GAP;
          gap_nxt   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (en) begin
          if (gap_cnt == '0) begin
            state_nxt = S_IDLE;
          end else begin
            gap_nxt = gap_cnt - 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        gap_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    issue = 1'b0;
    if (state == S_IDLE && en && !empty) begin
      pop   = 1'b1;
      issue = head_flagged;
    end
  end

  // ---------------------------------------------------------------------
  // Monitor-side output registers
  // ---------------------------------------------------------------------
  // The pulse flags are rebuilt from 'issue' every cycle, so a pulse lasts
  // exactly one cycle regardless of what en does afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      x1        <= '0;
      x2        <= '0;
      newX1     <= 1'b0;
      newX2     <= 1'b0;
      event_cnt <= '0;
    end else begin
      newX1 <= issue && head_has_x1;
      newX2 <= issue && head_has_x2;
      if (issue && head_has_x1) begin
        x1 <= head_x1;
      end
      if (issue && head_has_x2) begin
        x2 <= head_x2;
      end
      if (issue) begin
        event_cnt <= event_cnt + 16'd1;
      end
    end
  end

  assign busy       = !empty || (state == S_GAP);
  assign fifo_level = count;

endmodule
